// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: binary-to-BCD converter plus multiplexed seven-segment scan driver (optional blink via SEVEN_SEG_BLINK_EN)
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_WIDTH = 14,
  parameter int REFRESH_DIV = 100000
`ifdef SEVEN_SEG_BLINK_EN
  , parameter int BLINK_SLOTS = 256
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   value_valid,
  output logic                   ready,
  input  logic [NUM_DIGITS-1:0]  digit_en,
  input  logic [NUM_DIGITS-1:0]  dp_in,
  input  logic                   blank_leading,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]  blink_mask,
`endif
  output logic                   overflow,
  output logic [NUM_DIGITS-1:0]  an,
  output logic [6:0]             seg,
  output logic                   dp
);
  localparam int BCD_DIGITS = (VALUE_WIDTH + 2) / 3;
  localparam int SD = BCD_DIGITS > NUM_DIGITS ? BCD_DIGITS : NUM_DIGITS;
  localparam int SW = 4 * SD;
  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(VALUE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state;
  logic [VALUE_WIDTH-1:0] sh;
  logic [SW-1:0]          scratch;
  logic [SW-1:0]          adj;
  logic [CW-1:0]          bit_cnt;
  logic [DW-1:0]          bcd;
  logic                   ovf_next;
  logic [PW-1:0]          pre;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          nidx;
  logic                   wrap;
  logic [NUM_DIGITS-1:0]  upper_zero;
  logic                   z;
  logic [3:0]             nib;
  logic                   blank;
  logic                   blink_hide;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every scratch nibble that is 5 or more before the shift
  always_comb begin
    adj = scratch;
    for (int i = 0; i < SD; i++)
      adj[i*4 +: 4] = scratch[i*4 +: 4] >= 4'd5 ? scratch[i*4 +: 4] + 4'd3 : scratch[i*4 +: 4];
  end

  // Any nonzero nibble above the displayed ones means the value does not fit on the display
  always_comb begin
    ovf_next = 1'b0;
    for (int i = NUM_DIGITS; i < SD; i++)
      ovf_next = ovf_next | (|scratch[i*4 +: 4]);
  end

  // Converter FSM: capture, shift one bit per cycle, then commit the result in one step
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      sh       <= '0;
      scratch  <= '0;
      bit_cnt  <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (value_valid && ready) begin
          sh      <= value;
          scratch <= '0;
          bit_cnt <= '0;
          ready   <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          scratch <= {adj[SW-2:0], sh[VALUE_WIDTH-1]};
          sh      <= sh << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(VALUE_WIDTH - 1)) state <= COMMIT;
        end
        COMMIT: begin
          bcd      <= scratch[DW-1:0];
          overflow <= ovf_next;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero
  always_comb begin
    z = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (bcd[i*4 +: 4] == 4'd0);
      upper_zero[i] = z;
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int BW = BLINK_SLOTS > 1 ? $clog2(BLINK_SLOTS) : 1;
  logic          blink_on;
  logic [BW-1:0] blink_cnt;

  // Blink phase flips after BLINK_SLOTS complete scans and starts in the visible phase
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else if (wrap && idx == IW'(NUM_DIGITS - 1)) begin
      blink_cnt <= blink_cnt == BW'(BLINK_SLOTS - 1) ? '0 : blink_cnt + 1'b1;
      if (blink_cnt == BW'(BLINK_SLOTS - 1)) blink_on <= ~blink_on;
    end
  end

  assign blink_hide = !blink_on && blink_mask[nidx];
`else
  assign blink_hide = 1'b0;
`endif

  assign wrap  = pre == PW'(REFRESH_DIV - 1);
  assign nidx  = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
  assign nib   = bcd[nidx*4 +: 4];
  assign blank = !digit_en[nidx] || (!overflow && blank_leading && nidx != '0 && upper_zero[nidx]) || blink_hide;

  // Scan: prescaler wrap advances the digit and loads an/seg/dp for the new digit together
  always_ff @(posedge clock) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
      an  <= '1;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) begin
        idx <= nidx;
        an  <= blank ? '1 : ~(NUM_DIGITS'(1) << nidx);
        seg <= blank ? 7'b1111111 : overflow ? 7'b0111111 : enc(nib);
        dp  <= blank ? 1'b1 : ~dp_in[nidx];
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench for seven_seg_scanner with a fast refresh divider
module tb_seven_seg_scanner;
  localparam int ND = 4;
  localparam int VW = 14;
  localparam int RD = 4;

  typedef struct {
    int         idx;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ovf;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [VW-1:0] value = '0;
  logic          value_valid = 1'b0;
  logic          ready;
  logic [ND-1:0] digit_en = 4'hf;
  logic [ND-1:0] dp_in = 4'h0;
  logic          blank_leading = 1'b0;
  logic          overflow;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;
  int   cnt = 0;

  seven_seg_scanner #(.NUM_DIGITS(ND), .VALUE_WIDTH(VW), .REFRESH_DIV(RD)) dut (
    .clock(clock), .reset(reset), .value(value), .value_valid(value_valid), .ready(ready),
    .digit_en(digit_en), .dp_in(dp_in), .blank_leading(blank_leading), .overflow(overflow),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clock = ~clock;

  // Edges since reset release; outputs change at every RD-th edge, slot = (cnt/RD)%ND
  always @(posedge clock) cnt <= reset ? 0 : cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: at each slot start, pop the expected entry if it is for this slot
  always @(negedge clock) begin
    if (!reset && cnt > 0 && cnt % RD == 0 && q.size() > 0 && q[0].idx == (cnt / RD) % ND) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("slot%0d_an", e.idx), 32'(an), 32'(e.an));
      chk($sformatf("slot%0d_seg", e.idx), 32'(seg), 32'(e.seg));
      chk($sformatf("slot%0d_dp", e.idx), 32'(dp), 32'(e.dp));
      chk($sformatf("slot%0d_ovf", e.idx), 32'(overflow), 32'(e.ovf));
    end
  end

  task automatic push_scan(input logic [27:0] segs, input logic [3:0] vis, input logic [3:0] dpm, input logic ovf);
    int n;
    repeat (5) @(negedge clock);
    for (int i = 0; i < ND; i++) begin
      exp_t e;
      e.idx = i;
      e.an  = vis[i] ? ~(4'b1 << i) : 4'hf;
      e.seg = vis[i] ? segs[i*7 +: 7] : 7'h7f;
      e.dp  = vis[i] ? ~dpm[i] : 1'b1;
      e.ovf = ovf;
      q.push_back(e);
    end
    n = 0;
    while (q.size() > 0 && n < 48) begin
      @(negedge clock);
      n++;
    end
    chk("scan_drain", 32'(q.size()), 0);
    q.delete();
  endtask

  task automatic load(input logic [VW-1:0] v, input logic busy_en, input logic [VW-1:0] busy_v);
    int n;
    @(negedge clock);
    chk("ready_idle", 32'(ready), 1);
    value = v;
    value_valid = 1'b1;
    @(negedge clock);
    value_valid = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      n++;
      if (n == 3 && busy_en) begin
        value = busy_v;
        value_valid = 1'b1;
      end else value_valid = 1'b0;
      @(negedge clock);
    end
    value_valid = 1'b0;
    chk("ready_low_cycles", 32'(n), 15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_dp", 32'(dp), 1);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    push_scan({7'h40, 7'h40, 7'h40, 7'h40}, 4'hf, 4'h0, 1'b0);
    load(14'd1234, 1'b0, '0);
    push_scan({7'h79, 7'h24, 7'h30, 7'h19}, 4'hf, 4'h0, 1'b0);
    blank_leading = 1'b1;
    load(14'd7, 1'b0, '0);
    push_scan({7'h7f, 7'h7f, 7'h7f, 7'h78}, 4'h1, 4'h0, 1'b0);
    load(14'd10000, 1'b0, '0);
    push_scan({7'h3f, 7'h3f, 7'h3f, 7'h3f}, 4'hf, 4'h0, 1'b1);
    load(14'd42, 1'b0, '0);
    push_scan({7'h7f, 7'h7f, 7'h19, 7'h24}, 4'h3, 4'h0, 1'b0);
    blank_leading = 1'b0;
    dp_in = 4'b0100;
    load(14'd9, 1'b1, 14'd55);
    push_scan({7'h40, 7'h40, 7'h40, 7'h10}, 4'hf, 4'b0100, 1'b0);
    digit_en = 4'b1011;
    push_scan({7'h40, 7'h40, 7'h40, 7'h10}, 4'b1011, 4'b0100, 1'b0);
    digit_en = 4'hf;
    dp_in = 4'h0;
    @(negedge clock);
    value = 14'd9999;
    value_valid = 1'b1;
    @(negedge clock);
    value_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("midrst_an", 32'(an), 32'hf);
    chk("midrst_seg", 32'(seg), 32'h7f);
    chk("midrst_dp", 32'(dp), 1);
    chk("midrst_ready", 32'(ready), 1);
    chk("midrst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    push_scan({7'h40, 7'h40, 7'h40, 7'h40}, 4'hf, 4'h0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
